// File: rtl/bus_xfer_pkg.sv
// rtl/bus_xfer_pkg.sv - shared encodings and default widths for the bus transfer sequencer
package bus_xfer_pkg;

  localparam int NREG_DEF  = 4;
  localparam int IDX_W_DEF = 2;
  localparam int DW_DEF    = 4;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bus_xfer_dec.sv
// rtl/bus_xfer_dec.sv - register index to one-hot decoder with enable and out-of-range flag
module bus_xfer_dec
  import bus_xfer_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [NREG-1:0]  o_onehot,
  output logic             o_oor
);

  assign o_oor = (32'(i_idx) >= NREG);

  // one bit per register; an index past the last register lights nothing
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NREG; k++) begin
      if (i_en && (32'(i_idx) == k)) o_onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - one-command-at-a-time sequencer driving register file bus enables
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_src,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic [DW-1:0]    cmd_imm,
  output logic [NREG-1:0]  reg_oen,
  output logic [NREG-1:0]  reg_inen,
  output logic [NREG-1:0]  reg_clr,
  output logic             imm_oen,
  output logic [DW-1:0]    bus_imm,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_src, r_dst;
  logic [DW-1:0]    r_imm;
  logic             r_ill;
  logic             r_ready, r_imm_oen, r_busy, r_done, r_err;
  logic [NREG-1:0]  r_reg_oen, r_reg_inen, r_reg_clr;
  logic [DW-1:0]    r_bus_imm;

  state_t           w_nxt_state;
  logic [1:0]       w_nxt_op;
  logic [IDX_W-1:0] w_nxt_src, w_nxt_dst;
  logic [DW-1:0]    w_nxt_imm;
  logic             w_nxt_ill;
  logic             w_accept, w_cmd_ill, w_drive;
  logic             w_oen_en, w_imm_en, w_inen_en, w_clr_en;
  logic [NREG-1:0]  w_oen, w_inen, w_clr;
  logic             w_oen_oor, w_inen_oor, w_clr_oor, w_oor_any;

  assign w_accept  = cmd_valid && r_ready;

  // MOVE onto itself would leave the bus undriven while latching; bad indices have no register
  assign w_cmd_ill = ((cmd_op == OP_MOVE) &&
                      ((cmd_src == cmd_dst) || (32'(cmd_src) >= NREG) || (32'(cmd_dst) >= NREG))) ||
                     (((cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR)) && (32'(cmd_dst) >= NREG));

  // next state and next captured fields; outputs are decoded from these and then flopped
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_nxt_src   = r_src;
    w_nxt_dst   = r_dst;
    w_nxt_imm   = r_imm;
    w_nxt_ill   = r_ill;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_nxt_op    = cmd_op;
          w_nxt_src   = cmd_src;
          w_nxt_dst   = cmd_dst;
          w_nxt_imm   = cmd_imm;
          w_nxt_ill   = w_cmd_ill;
          w_nxt_state = ((cmd_op == OP_NOP) || w_cmd_ill) ? ST_DONE : ST_SETUP;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_SETUP: w_nxt_state = ST_LATCH;
      ST_LATCH: w_nxt_state = ST_HOLD;
      ST_HOLD:  w_nxt_state = ST_DONE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  // source stays on through SETUP/LATCH/HOLD so the bus settles before and after the latch edge
  assign w_drive   = (w_nxt_state == ST_SETUP) || (w_nxt_state == ST_LATCH) || (w_nxt_state == ST_HOLD);
  assign w_oen_en  = w_drive && (w_nxt_op == OP_MOVE);
  assign w_imm_en  = w_drive && (w_nxt_op == OP_LOAD);
  assign w_inen_en = (w_nxt_state == ST_LATCH) && ((w_nxt_op == OP_MOVE) || (w_nxt_op == OP_LOAD));
  assign w_clr_en  = (w_nxt_state == ST_LATCH) && (w_nxt_op == OP_CLEAR);

  bus_xfer_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_oen (
    .i_en(w_oen_en), .i_idx(w_nxt_src), .o_onehot(w_oen), .o_oor(w_oen_oor)
  );
  bus_xfer_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_inen (
    .i_en(w_inen_en), .i_idx(w_nxt_dst), .o_onehot(w_inen), .o_oor(w_inen_oor)
  );
  bus_xfer_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_clr (
    .i_en(w_clr_en), .i_idx(w_nxt_dst), .o_onehot(w_clr), .o_oor(w_clr_oor)
  );

  // any out-of-range index in flight forces the register strobes off as a last line of defence
  assign w_oor_any = (w_oen_en & w_oen_oor) | (w_inen_en & w_inen_oor) | (w_clr_en & w_clr_oor);

  // state, captured command and every output flop; reset drops all enables without a clock
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NOP;
      r_src      <= '0;
      r_dst      <= '0;
      r_imm      <= '0;
      r_ill      <= 1'b0;
      r_ready    <= 1'b1;
      r_reg_oen  <= '0;
      r_reg_inen <= '0;
      r_reg_clr  <= '0;
      r_imm_oen  <= 1'b0;
      r_bus_imm  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_op       <= w_nxt_op;
      r_src      <= w_nxt_src;
      r_dst      <= w_nxt_dst;
      r_imm      <= w_nxt_imm;
      r_ill      <= w_nxt_ill;
      r_ready    <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_DONE);
      r_reg_oen  <= w_oor_any ? '0 : w_oen;
      r_reg_inen <= w_oor_any ? '0 : w_inen;
      r_reg_clr  <= w_oor_any ? '0 : w_clr;
      r_imm_oen  <= w_imm_en;
      r_bus_imm  <= w_imm_en ? w_nxt_imm : '0;
      r_busy     <= (w_nxt_state != ST_IDLE);
      r_done     <= (w_nxt_state == ST_DONE);
      r_err      <= (w_nxt_state == ST_DONE) && w_nxt_ill;
    end
  end

  assign cmd_ready = r_ready;
  assign reg_oen   = r_reg_oen;
  assign reg_inen  = r_reg_inen;
  assign reg_clr   = r_reg_clr;
  assign imm_oen   = r_imm_oen;
  assign bus_imm   = r_bus_imm;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed and randomised checks of the bus transfer sequencer
module tb_bus_xfer_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b11;
  logic [1:0] cmd_src = '0;
  logic [1:0] cmd_dst = '0;
  logic [3:0] cmd_imm = '0;
  logic [3:0] reg_oen, reg_inen, reg_clr;
  logic       imm_oen;
  logic [3:0] bus_imm;
  logic       busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  bus_xfer_ctrl #(.NREG(4), .IDX_W(2), .DW(4)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .reg_oen(reg_oen), .reg_inen(reg_inen), .reg_clr(reg_clr),
    .imm_oen(imm_oen), .bus_imm(bus_imm), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue a 4-cycle command and check every cycle up to and including DONE
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] src,
                         input logic [1:0] dst, input logic [3:0] imm, input logic hold,
                         input logic [3:0] e_oen, input logic e_imm, input logic [3:0] e_inen,
                         input logic [3:0] e_clr, input logic [3:0] e_bus);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm; cmd_valid = 1'b1;
    step();
    cmd_valid = hold;
    cmd_src = ~src; cmd_dst = ~dst; cmd_imm = ~imm;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      chk($sformatf("%s c%0d oen", tag, c), reg_oen, (c <= 3) ? e_oen : 4'd0);
      chk($sformatf("%s c%0d imm_oen", tag, c), imm_oen, (c <= 3) ? e_imm : 1'b0);
      chk($sformatf("%s c%0d inen", tag, c), reg_inen, (c == 2) ? e_inen : 4'd0);
      chk($sformatf("%s c%0d clr", tag, c), reg_clr, (c == 2) ? e_clr : 4'd0);
      chk($sformatf("%s c%0d bus_imm", tag, c), bus_imm, (c <= 3) ? e_bus : 4'd0);
      chk($sformatf("%s c%0d done", tag, c), done, c == 4);
      chk($sformatf("%s c%0d err", tag, c), err, 1'b0);
      chk($sformatf("%s c%0d ready", tag, c), cmd_ready, c == 4);
      chk($sformatf("%s c%0d busy", tag, c), busy, 1'b1);
    end
  endtask

  // issue a NOP or illegal command: DONE immediately, then back to IDLE
  task automatic run_short(input string tag, input logic [1:0] op, input logic [1:0] src,
                           input logic [1:0] dst, input logic e_err);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = 4'hF; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (c > 1) step();
      chk($sformatf("%s c%0d done", tag, c), done, c == 1);
      chk($sformatf("%s c%0d err", tag, c), err, (c == 1) ? e_err : 1'b0);
      chk($sformatf("%s c%0d busy", tag, c), busy, c == 1);
      chk($sformatf("%s c%0d strobes", tag, c), {reg_oen, reg_inen, reg_clr, imm_oen}, 13'd0);
    end
  endtask

  initial begin
    bit         acc;
    bit         m_active;
    int         m_rem;
    int         n_acc;
    int         n_done;
    logic [1:0] r_op, r_src, r_dst;

    // reset state
    step();
    step();
    chk("rst strobes", {reg_oen, reg_inen, reg_clr, imm_oen}, 13'd0);
    chk("rst bus_imm", bus_imm, 4'd0);
    chk("rst busy/done/err", {busy, done, err}, 3'b000);
    clr = 1'b1;
    chk("rst ready", cmd_ready, 1'b1);

    // reset in the middle of LATCH of MOVE 1->2
    cmd_op = 2'b00; cmd_src = 2'd1; cmd_dst = 2'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("mvrst setup oen", reg_oen, 4'b0010);
    step();
    chk("mvrst latch inen", reg_inen, 4'b0100);
    chk("mvrst latch oen", reg_oen, 4'b0010);
    #2 clr = 1'b0;
    #1;
    chk("mvrst async oen", reg_oen, 4'd0);
    chk("mvrst async inen", reg_inen, 4'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mvrst held done", done, 1'b0);
    end
    clr = 1'b1;
    chk("mvrst post ready", cmd_ready, 1'b1);
    chk("mvrst post busy", busy, 1'b0);
    step();
    chk("mvrst no done", done, 1'b0);
    chk("mvrst idle busy", busy, 1'b0);

    // LOAD 5 -> r3, then MOVE r3 -> r0 accepted at DONE
    run_cmd("load5", 2'b01, 2'd1, 2'd3, 4'b0101, 1'b0, 4'd0, 1'b1, 4'b1000, 4'd0, 4'd5);
    run_cmd("mv30", 2'b00, 2'd3, 2'd0, 4'h7, 1'b0, 4'b1000, 1'b0, 4'b0001, 4'd0, 4'd0);

    // back-to-back with cmd_valid held high
    run_cmd("b2b ldD", 2'b01, 2'd0, 2'd1, 4'hD, 1'b1, 4'd0, 1'b1, 4'b0010, 4'd0, 4'hD);
    run_cmd("b2b clr1", 2'b10, 2'd0, 2'd1, 4'h3, 1'b1, 4'd0, 1'b0, 4'd0, 4'b0010, 4'd0);
    run_cmd("b2b ldA", 2'b01, 2'd3, 2'd2, 4'hA, 1'b1, 4'd0, 1'b1, 4'b0100, 4'd0, 4'hA);
    cmd_valid = 1'b0;
    step();
    chk("b2b idle busy", busy, 1'b0);
    chk("b2b idle ready", cmd_ready, 1'b1);

    // illegal MOVE 2->2, then NOP
    run_short("ill mv22", 2'b00, 2'd2, 2'd2, 1'b1);
    run_short("nop", 2'b11, 2'd1, 2'd0, 1'b0);

    // random traffic; reference model counts cycles to DONE
    m_active = 1'b0; m_rem = 0; n_acc = 0; n_done = 0;
    for (int cyc = 0; cyc < 220; cyc++) begin
      cmd_valid = (cyc < 200) ? ($urandom_range(0, 1) == 1) : 1'b0;
      r_op = 2'($urandom_range(0, 3));
      r_src = 2'($urandom_range(0, 3));
      r_dst = 2'($urandom_range(0, 3));
      cmd_op = r_op; cmd_src = r_src; cmd_dst = r_dst; cmd_imm = 4'($urandom_range(0, 15));
      acc = cmd_valid && (!m_active || (m_rem == 0));
      step();
      if (acc) begin
        n_acc++;
        m_active = 1'b1;
        m_rem = ((r_op == 2'b11) || ((r_op == 2'b00) && (r_src == r_dst))) ? 0 : 3;
      end else if (m_active && (m_rem > 0)) begin
        m_rem--;
      end else begin
        m_active = 1'b0;
      end
      if (done) n_done++;
      chk("rnd done", done, m_active && (m_rem == 0));
      chk("rnd ready", cmd_ready, !m_active || (m_rem == 0));
      chk("rnd busy", busy, m_active);
      chk("rnd one driver", ($countones(reg_oen) + imm_oen) <= 1, 1'b1);
      chk("rnd one latch", $countones(reg_inen) <= 1, 1'b1);
      chk("rnd inen/clr excl", (reg_inen != 0) && (reg_clr != 0), 1'b0);
      chk("rnd inen needs driver", (reg_inen != 0) && (reg_oen == 0) && !imm_oen, 1'b0);
      chk("rnd bus_imm gated", !imm_oen && (bus_imm != 0), 1'b0);
    end
    chk("rnd done==acc", n_done, n_acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
